uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single `uart` transmitter among `N_REQ` byte producers (key scanner, synth status, debug echo, …). It arbitrates between pending requests, latches the winner's byte, and drives the uart's level-sensitive `send` / `send_data` inputs. It tracks the uart's send state to completion and returns a one-cycle acknowledge to the winning requester. It sits between the producers and `uart`, on the same fast clock that feeds the uart's state registers.

---
 rtl/uart_tx_sched_if.sv | 32 +++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_sched_if                                                |
// | Purpose  : Producer-side request/ack bundle plus the uart send/status pins. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface uart_tx_sched_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic               timeout;
    logic               busy;
    logic [2:0]         cur_id;
    logic               uart_send;
    logic [7:0]         uart_data;
    logic [3:0]         uart_sta;
    logic               uart_send_done;

    modport master (
        input  req, req_data, uart_sta, uart_send_done,
        output ack, timeout, busy, cur_id, uart_send, uart_data
    );

    modport slave (
        output req, req_data, uart_sta, uart_send_done,
        input  ack, timeout, busy, cur_id, uart_send, uart_data
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_sched                                                   |
// | Purpose  : Round-robin sharing of one uart transmitter among N_REQ sources. |
// |            Optional watchdog enabled by macro UART_SCHED_TIMEOUT_EN.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx_sched #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_tx_sched_if.master   bus
);
    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        IDLE   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       last_q, last_d;
    logic [2:0]       cur_id_q, cur_id_d;
    logic [7:0]       uart_data_q, uart_data_d;
    logic             uart_send_q, uart_send_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             timeout_q, timeout_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] above_last;
    logic [N_REQ-1:0] req_hi;
    logic [2:0]       winner;
    logic [7:0]       win_byte;
    logic [N_REQ-1:0] cur_onehot;
    logic             cnt_hit;

    function automatic logic [2:0] lowest_set(input logic [N_REQ-1:0] v);
        lowest_set = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (v[j]) lowest_set = 3'(j);
        end
    endfunction

    // Requests above the pointer win first; otherwise wrap to the lowest index.
    always_comb begin
        for (int j = 0; j < N_REQ; j++) begin
            above_last[j] = (3'(j) > last_q);
        end
        req_hi   = bus.req & above_last;
        winner   = (req_hi != '0) ? lowest_set(req_hi) : lowest_set(bus.req);
        win_byte = '0;
        cur_onehot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (3'(j) == winner)   win_byte      = bus.req_data[8*j +: 8];
            if (3'(j) == cur_id_q) cur_onehot[j] = 1'b1;
        end
    end

`ifdef UART_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (state_q == LAUNCH || state_q == WAIT) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign cnt_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        cur_id_d    = cur_id_q;
        uart_data_d = uart_data_q;
        uart_send_d = uart_send_q;
        ack_d       = '0;
        timeout_d   = 1'b0;
        case (state_q)
            SYNC: begin
                if (bus.uart_sta == 4'd0) state_d = IDLE;
            end
            IDLE: begin
                if (bus.req != '0 && bus.uart_sta == 4'd0) begin
                    cur_id_d    = winner;
                    last_d      = winner;
                    uart_data_d = win_byte;
                    uart_send_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH, WAIT: begin
                if (cnt_hit) begin
                    uart_send_d = 1'b0;
                    ack_d       = cur_onehot;
                    timeout_d   = 1'b1;
                    state_d     = ACK;
                end else if (state_q == LAUNCH) begin
                    // Nonzero status means the uart has taken the send level.
                    if (bus.uart_sta != 4'd0) begin
                        uart_send_d = 1'b0;
                        state_d     = WAIT;
                    end
                end else if (bus.uart_sta == 4'd0 && bus.uart_send_done) begin
                    ack_d   = cur_onehot;
                    state_d = ACK;
                end
            end
            ACK: begin
                // An aborted frame leaves the uart in an unknown state: resync.
                state_d = timeout_q ? SYNC : IDLE;
            end
            default: state_d = SYNC;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            last_q      <= 3'(N_REQ - 1);
            cur_id_q    <= '0;
            uart_data_q <= '0;
            uart_send_q <= 1'b0;
            ack_q       <= '0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cur_id_q    <= cur_id_d;
            uart_data_q <= uart_data_d;
            uart_send_q <= uart_send_d;
            ack_q       <= ack_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = busy_q;
    assign bus.cur_id    = cur_id_q;
    assign bus.uart_send = uart_send_q;
    assign bus.uart_data = uart_data_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_sched                                                |
// | Purpose  : Randomized and directed bench for uart_tx_sched with uart model. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int TO = 100;
`ifdef UART_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   tb_req  = '0;
    logic [8*N-1:0] tb_data = '0;
    logic [3:0]     u_sta   = 4'd0;
    logic           u_done  = 1'b0;

    uart_tx_sched_if #(.N_REQ(N)) bus ();
    assign bus.req            = tb_req;
    assign bus.req_data       = tb_data;
    assign bus.uart_sta       = u_sta;
    assign bus.uart_send_done = u_done;

    uart_tx_sched #(.N_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Uart model: samples send when idle, status counts down the frame, done on return to 0.
    int         u_left    = 0;
    bit         stuck     = 1'b0;
    logic [7:0] sent_q[$];
    logic [7:0] last_sent = 8'h00;
    always @(posedge clk) begin
        int n;
        cyc_n <= cyc_n + 1;
        if (u_left == 0) begin
            u_done <= 1'b0;
            if (bus.uart_send && !stuck) begin
                n = $urandom_range(6, 15);
                u_left    <= n;
                u_sta     <= 4'(n);
                last_sent <= bus.uart_data;
                sent_q.push_back(bus.uart_data);
            end
        end else begin
            u_left <= u_left - 1;
            u_sta  <= 4'(u_left - 1);
            if (u_left == 1) u_done <= 1'b1;
        end
    end

    // Reference model: transaction phases derived from the behavioural rules.
    bit         m_sync = 1'b1, m_serve = 1'b0, m_launched = 1'b0, m_acking = 1'b0, m_to = 1'b0;
    int         m_age  = 0;
    int         m_last = N - 1;
    logic       exp_send = 1'b0, exp_to = 1'b0, exp_busy = 1'b1;
    logic [7:0] exp_data = 8'h00;
    logic [N-1:0] exp_ack = '0;
    logic [2:0] exp_cur = 3'd0;
    logic [7:0] exp_bytes[$];
    always @(posedge clk) begin
        int w;
        w = 0;
        if (rst) begin
            m_sync <= 1'b1; m_serve <= 1'b0; m_launched <= 1'b0; m_acking <= 1'b0; m_to <= 1'b0;
            m_last <= N - 1; exp_send <= 1'b0; exp_data <= 8'h00; exp_ack <= '0;
            exp_to <= 1'b0; exp_busy <= 1'b1; exp_cur <= 3'd0;
            exp_bytes.delete();
        end else begin
            exp_ack <= '0;
            exp_to  <= 1'b0;
            if (m_sync) begin
                if (u_sta == 4'd0) begin m_sync <= 1'b0; exp_busy <= 1'b0; end
            end else if (m_acking) begin
                m_acking <= 1'b0;
                if (m_to) begin m_sync <= 1'b1; m_to <= 1'b0; end
                else exp_busy <= 1'b0;
            end else if (m_serve) begin
                m_age <= m_age + 1;
                if (TO_EN && m_age + 1 == TO) begin
                    exp_send <= 1'b0; exp_ack <= N'(1) << exp_cur; exp_to <= 1'b1;
                    m_to <= 1'b1; m_serve <= 1'b0; m_acking <= 1'b1;
                    exp_bytes.delete();
                end else if (!m_launched) begin
                    if (u_sta != 4'd0) begin exp_send <= 1'b0; m_launched <= 1'b1; end
                end else if (u_sta == 4'd0 && u_done) begin
                    exp_ack <= N'(1) << exp_cur; m_serve <= 1'b0; m_acking <= 1'b1;
                end
            end else if (tb_req != '0 && u_sta == 4'd0) begin
                for (int k = 1; k <= N; k++) begin
                    if (tb_req[(m_last + k) % N]) begin w = (m_last + k) % N; break; end
                end
                exp_cur <= 3'(w); m_last <= w; exp_data <= tb_data[8*w +: 8];
                exp_send <= 1'b1; exp_busy <= 1'b1; m_serve <= 1'b1; m_launched <= 1'b0; m_age <= 0;
                exp_bytes.push_back(tb_data[8*w +: 8]);
            end
        end
    end

    // Monitors and per-cycle comparison against the model.
    int   ack_cnt[N];
    int   grant_log[$];
    int   grant_cyc = 0;
    logic prev_send = 1'b0;
    initial for (int i = 0; i < N; i++) ack_cnt[i] = 0;
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) ack_cnt[i] += int'(bus.ack[i]);
        if (bus.uart_send === 1'b1 && prev_send !== 1'b1) begin
            grant_log.push_back(int'(bus.cur_id));
            grant_cyc = cyc_n;
        end
        prev_send = bus.uart_send;
        if (chk_en) begin
            check("uart_send", 32'(bus.uart_send), 32'(exp_send));
            check("uart_data", 32'(bus.uart_data), 32'(exp_data));
            check("ack",       32'(bus.ack),       32'(exp_ack));
            check("timeout",   32'(bus.timeout),   32'(exp_to));
            check("busy",      32'(bus.busy),      32'(exp_busy));
            check("cur_id",    32'(bus.cur_id),    32'(exp_cur));
            while (sent_q.size() > 0 && exp_bytes.size() > 0)
                check("serial_byte", 32'(sent_q.pop_front()), 32'(exp_bytes.pop_front()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input int bound);
        int k;
        for (k = 0; k < bound && bus.busy !== 1'b0; k++) cyc(1);
        if (k >= bound) check("wait_idle_bound", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_ack(input int id, input int bound);
        int k;
        for (k = 0; k < bound; k++) begin
            cyc(1);
            if (bus.ack[id] === 1'b1) break;
        end
        if (k >= bound) check("wait_ack_bound", 32'(bus.ack), 32'(1 << id));
    endtask

    int base;
    initial begin
        cyc(3);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_send", 32'(bus.uart_send), 32'd0);
        check("rst_cur_id", 32'(bus.cur_id), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        wait_idle(50);

        // Single request, one-cycle grant latency.
        base = ack_cnt[0];
        tb_data[7:0] = 8'hA5;
        tb_req = 4'b0001;
        cyc(1);
        check("single_send_rise", 32'(bus.uart_send), 32'd1);
        check("single_data", 32'(bus.uart_data), 32'hA5);
        wait_ack(0, 100);
        tb_req = '0;
        wait_idle(50);
        check("single_ack_count", 32'(ack_cnt[0] - base), 32'd1);
        check("single_serial", 32'(last_sent), 32'hA5);

        // Fairness from a fresh reset: pointer starts at N-1.
        rst = 1'b1; cyc(1); rst = 1'b0;
        grant_log.delete();
        tb_req = 4'b1111;
        for (int k = 0; k < 500 && grant_log.size() < 5; k++) cyc(1);
        check("fair_count", 32'(grant_log.size() >= 5), 32'd1);
        if (grant_log.size() >= 5) begin
            check("fair_g0", 32'(grant_log[0]), 32'd0);
            check("fair_g1", 32'(grant_log[1]), 32'd1);
            check("fair_g2", 32'(grant_log[2]), 32'd2);
            check("fair_g3", 32'(grant_log[3]), 32'd3);
            check("fair_g4", 32'(grant_log[4]), 32'd0);
        end
        tb_req = '0;
        wait_idle(100);

        // Byte latched at grant; later req_data changes ignored.
        tb_data[15:8] = 8'h11;
        tb_req = 4'b0010;
        for (int k = 0; k < 50 && u_sta == 4'd0; k++) cyc(1);
        cyc(2);
        tb_data[15:8] = 8'h22;
        wait_ack(1, 100);
        tb_req = '0;
        check("latch_serial", 32'(last_sent), 32'h11);
        wait_idle(50);

        // Reset while the uart is mid-frame.
        tb_data[7:0] = 8'h3C;
        tb_req = 4'b0001;
        for (int k = 0; k < 100 && u_sta != 4'd5; k++) cyc(1);
        check("rst_mid_sta", 32'(u_sta), 32'd5);
        rst = 1'b1;
        tb_req = 4'b0100;
        tb_data[23:16] = 8'h77;
        cyc(1);
        check("rst_mid_busy", 32'(bus.busy), 32'd1);
        check("rst_mid_send", 32'(bus.uart_send), 32'd0);
        check("rst_mid_data", 32'(bus.uart_data), 32'd0);
        rst = 1'b0;
        wait_ack(2, 100);
        tb_req = '0;
        check("rst_mid_regrant", 32'(last_sent), 32'h77);
        wait_idle(50);

        // Requester drops req during LAUNCH.
        base = ack_cnt[2];
        tb_data[23:16] = 8'h5A;
        tb_req = 4'b0100;
        cyc(1);
        tb_req = '0;
        wait_idle(100);
        cyc(2);
        check("drop_ack_count", 32'(ack_cnt[2] - base), 32'd1);
        check("drop_idle_busy", 32'(bus.busy), 32'd0);

`ifdef UART_SCHED_TIMEOUT_EN
        stuck = 1'b1;
        tb_req = 4'b0001;
        wait_ack(0, 300);
        check("wd_timeout", 32'(bus.timeout), 32'd1);
        check("wd_latency", 32'(cyc_n - grant_cyc), 32'(TO));
        tb_req = '0;
        stuck = 1'b0;
        wait_idle(50);
`endif

        // Randomized producers with random data churn.
        for (int c = 0; c < 3000; c++) begin
            cyc(1);
            for (int i = 0; i < N; i++) begin
                if (bus.ack[i] === 1'b1)
                    tb_req[i] = ($urandom_range(0, 3) == 0);
                else if (!tb_req[i] && $urandom_range(0, 7) == 0) begin
                    tb_req[i] = 1'b1;
                    tb_data[8*i +: 8] = 8'($urandom);
                end else if (tb_req[i] && $urandom_range(0, 99) == 0)
                    tb_req[i] = 1'b0;
                if ($urandom_range(0, 15) == 0) tb_data[8*i +: 8] = 8'($urandom);
            end
        end
        tb_req = '0;
        wait_idle(100);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
`default_nettype wire
